// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing one memory-controller port between icache and dcache.
// Optional watchdog abort enabled by defining ARB_TIMEOUT_EN.
module cache_mem_arbiter #(
  parameter int ADDRBITS = 32,
  parameter int DATABITS = 32,
  parameter int BLBITS   = 16,
  parameter int TIMEOUT  = 1023
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDRBITS-1:0] ic_addr,
  input  logic                ic_rdreq,
  input  logic [BLBITS-1:0]   ic_burstlen,
  output logic [DATABITS-1:0] ic_dataout,
  output logic                ic_valid,
  input  logic [ADDRBITS-1:0] dc_addr,
  input  logic [DATABITS-1:0] dc_datain,
  input  logic                dc_rdreq,
  input  logic                dc_wrreq,
  input  logic [BLBITS-1:0]   dc_burstlen,
  output logic [DATABITS-1:0] dc_dataout,
  output logic                dc_valid,
  input  logic [DATABITS-1:0] mem_out,
  input  logic                mem_valid,
  output logic [ADDRBITS-1:0] mem_addr,
  output logic [DATABITS-1:0] mem_in,
  output logic                mem_rdreq,
  output logic                mem_wrreq,
  output logic [BLBITS-1:0]   mem_burstlen,
  output logic                arb_timeout
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_IC = 2'd1,
    GNT_DC = 2'd2,
    GAP    = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic              last_dc;
  logic [BLBITS-1:0] beat_cnt;
  logic              ic_req;
  logic              dc_req;
  logic              in_gnt;
  logic              own_req;
  logic [BLBITS-1:0] own_bl;
  logic [BLBITS-1:0] bl_last;
  logic              last_beat;
  logic              tmo;

  assign ic_req = ic_rdreq;
  assign dc_req = dc_rdreq | dc_wrreq;
  assign in_gnt = (state == GNT_IC) || (state == GNT_DC);

  always_comb begin
    own_req = 1'b0;
    own_bl  = '0;
    unique case (1'b1)
      (state == GNT_IC): begin
        own_req = ic_req;
        own_bl  = ic_burstlen;
      end
      (state == GNT_DC): begin
        own_req = dc_req;
        own_bl  = dc_burstlen;
      end
      default: ;
    endcase
  end

  // A zero burst length behaves as a single beat.
  assign bl_last   = (own_bl == '0) ? '0 : own_bl - 1'b1;
  assign last_beat = in_gnt && mem_valid && (beat_cnt == bl_last);

`ifdef ARB_TIMEOUT_EN
  localparam int WDBITS = $clog2(TIMEOUT + 1);
  logic [WDBITS-1:0] wd_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt <= '0;
    end else if (!in_gnt || mem_valid) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  assign tmo = in_gnt && (wd_cnt == WDBITS'(TIMEOUT));
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_dc  <= 1'b1;
      beat_cnt <= '0;
    end else begin
      if (state == IDLE && state_nx != IDLE) begin
        last_dc <= (state_nx == GNT_DC);
      end
      if (in_gnt && state_nx == state) begin
        beat_cnt <= mem_valid ? beat_cnt + 1'b1 : beat_cnt;
      end else begin
        beat_cnt <= '0;
      end
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (ic_req && dc_req) begin
          state_nx = last_dc ? GNT_IC : GNT_DC;
        end else if (ic_req) begin
          state_nx = GNT_IC;
        end else if (dc_req) begin
          state_nx = GNT_DC;
        end
      end
      GNT_IC, GNT_DC: begin
        if (tmo || last_beat) begin
          state_nx = GAP;
        end else if (!own_req) begin
          state_nx = IDLE;
        end
      end
      GAP: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    mem_addr     = '0;
    mem_in       = '0;
    mem_burstlen = '0;
    mem_rdreq    = 1'b0;
    mem_wrreq    = 1'b0;
    ic_valid     = 1'b0;
    ic_dataout   = '0;
    dc_valid     = 1'b0;
    dc_dataout   = '0;
    arb_timeout  = tmo;
    unique case (1'b1)
      (state == GNT_IC): begin
        mem_addr     = ic_addr;
        mem_burstlen = ic_burstlen;
        mem_rdreq    = ic_rdreq & ~tmo;
        ic_valid     = mem_valid;
        ic_dataout   = mem_out;
      end
      (state == GNT_DC): begin
        mem_addr     = dc_addr;
        mem_in       = dc_datain;
        mem_burstlen = dc_burstlen;
        mem_wrreq    = dc_wrreq & ~tmo;
        mem_rdreq    = dc_rdreq & ~dc_wrreq & ~tmo;
        dc_valid     = mem_valid;
        dc_dataout   = mem_out;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter (default build, watchdog off).
// Grant-level model checked every cycle plus directed literal checks.
module tb_cache_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [31:0] ic_addr = '0;
  logic        ic_rdreq = 1'b0;
  logic [15:0] ic_burstlen = '0;
  logic [31:0] ic_dataout;
  logic        ic_valid;
  logic [31:0] dc_addr = '0;
  logic [31:0] dc_datain = '0;
  logic        dc_rdreq = 1'b0;
  logic        dc_wrreq = 1'b0;
  logic [15:0] dc_burstlen = '0;
  logic [31:0] dc_dataout;
  logic        dc_valid;
  logic [31:0] mem_out = '0;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_addr;
  logic [31:0] mem_in;
  logic        mem_rdreq;
  logic        mem_wrreq;
  logic [15:0] mem_burstlen;
  logic        arb_timeout;

  always #5 clk = ~clk;

  cache_mem_arbiter #(
    .ADDRBITS(32),
    .DATABITS(32),
    .BLBITS(16),
    .TIMEOUT(1023)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .ic_addr(ic_addr),
    .ic_rdreq(ic_rdreq),
    .ic_burstlen(ic_burstlen),
    .ic_dataout(ic_dataout),
    .ic_valid(ic_valid),
    .dc_addr(dc_addr),
    .dc_datain(dc_datain),
    .dc_rdreq(dc_rdreq),
    .dc_wrreq(dc_wrreq),
    .dc_burstlen(dc_burstlen),
    .dc_dataout(dc_dataout),
    .dc_valid(dc_valid),
    .mem_out(mem_out),
    .mem_valid(mem_valid),
    .mem_addr(mem_addr),
    .mem_in(mem_in),
    .mem_rdreq(mem_rdreq),
    .mem_wrreq(mem_wrreq),
    .mem_burstlen(mem_burstlen),
    .arb_timeout(arb_timeout)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Model: who owns the port (0 none, 1 icache, 2 dcache), beats delivered.
  int m_own = 0;
  bit m_gap = 1'b0;
  int m_last = 2;
  int m_beats = 0;

  always @(posedge clk or negedge reset_n) begin : mdl
    int nxt;
    int bl;
    bit req;
    if (!reset_n) begin
      m_own   <= 0;
      m_gap   <= 1'b0;
      m_last  <= 2;
      m_beats <= 0;
    end else if (m_gap) begin
      m_gap <= 1'b0;
    end else if (m_own == 0) begin
      nxt = 0;
      if (ic_rdreq && (dc_rdreq || dc_wrreq)) nxt = (m_last == 1) ? 2 : 1;
      else if (ic_rdreq) nxt = 1;
      else if (dc_rdreq || dc_wrreq) nxt = 2;
      m_own <= nxt;
      if (nxt != 0) m_last <= nxt;
      m_beats <= 0;
    end else begin
      req = (m_own == 1) ? ic_rdreq : (dc_rdreq || dc_wrreq);
      bl  = (m_own == 1) ? int'(ic_burstlen) : int'(dc_burstlen);
      if (bl == 0) bl = 1;
      if (mem_valid && (m_beats + 1 == bl)) begin
        m_own   <= 0;
        m_gap   <= 1'b1;
        m_beats <= 0;
      end else if (!req) begin
        m_own   <= 0;
        m_beats <= 0;
      end else if (mem_valid) begin
        m_beats <= m_beats + 1;
      end
    end
  end

  always @(negedge clk) begin : cmp
    logic [31:0] ea, ei, edi, edd;
    logic [15:0] eb;
    logic er, ew, evi, evd;
    ea = '0; ei = '0; edi = '0; edd = '0; eb = '0;
    er = 1'b0; ew = 1'b0; evi = 1'b0; evd = 1'b0;
    if (m_own == 1) begin
      ea = ic_addr; eb = ic_burstlen; er = ic_rdreq;
      evi = mem_valid; edi = mem_out;
    end else if (m_own == 2) begin
      ea = dc_addr; ei = dc_datain; eb = dc_burstlen;
      ew = dc_wrreq; er = dc_rdreq && !dc_wrreq;
      evd = mem_valid; edd = mem_out;
    end
    chk("mem_addr", mem_addr, ea);
    chk("mem_in", mem_in, ei);
    chk("mem_burstlen", mem_burstlen, eb);
    chk("mem_rdreq", mem_rdreq, er);
    chk("mem_wrreq", mem_wrreq, ew);
    chk("ic_valid", ic_valid, evi);
    chk("ic_dataout", ic_dataout, edi);
    chk("dc_valid", dc_valid, evd);
    chk("dc_dataout", dc_dataout, edd);
    chk("arb_timeout", arb_timeout, 1'b0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int q[$];

    // reset
    #1 reset_n = 1'b0;
    #1;
    chk("rst_rdreq", mem_rdreq, 1'b0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_icvalid", ic_valid, 1'b0);
    chk("rst_timeout", arb_timeout, 1'b0);
    step();
    step();
    reset_n = 1'b1;

    // icache alone, 4 beats
    ic_addr = 32'h1000; ic_burstlen = 16'd4; ic_rdreq = 1'b1;
    #1 chk("t1_idle_rdreq", mem_rdreq, 1'b0);
    step();
    chk("t1_gnt_rdreq", mem_rdreq, 1'b1);
    chk("t1_gnt_addr", mem_addr, 32'h1000);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      mem_valid = 1'b1; mem_out = 32'hA0 + 32'(i);
      #1;
      if (ic_valid) n++;
      chk("t1_data", ic_dataout, 32'hA0 + 32'(i));
      step();
    end
    mem_valid = 1'b0; ic_rdreq = 1'b0;
    #1 chk("t1_gap_rdreq", mem_rdreq, 1'b0);
    chk("t1_beats", n, 4);
    step();

    // simultaneous icache read and dcache write after reset
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    ic_addr = 32'h1100; ic_burstlen = 16'd1; ic_rdreq = 1'b1;
    dc_addr = 32'h2000; dc_datain = 32'hDEADBEEF; dc_burstlen = 16'd2;
    dc_wrreq = 1'b1;
    step();
    chk("t2_ic_rdreq", mem_rdreq, 1'b1);
    chk("t2_ic_wrreq", mem_wrreq, 1'b0);
    chk("t2_ic_addr", mem_addr, 32'h1100);
    mem_valid = 1'b1; mem_out = 32'h55;
    #1 chk("t2_ic_valid", ic_valid, 1'b1);
    chk("t2_dc_valid", dc_valid, 1'b0);
    step();
    mem_valid = 1'b0; ic_rdreq = 1'b0;
    #1 chk("t2_gap_rdreq", mem_rdreq, 1'b0);
    step();
    step();
    chk("t2_dc_wrreq", mem_wrreq, 1'b1);
    chk("t2_dc_in", mem_in, 32'hDEADBEEF);
    chk("t2_dc_rdreq", mem_rdreq, 1'b0);
    mem_valid = 1'b1;
    step();
    step();
    mem_valid = 1'b0; dc_wrreq = 1'b0;
    step();

    // continuous requests, single beats: grants alternate
    ic_addr = 32'h4000; dc_addr = 32'h5000;
    ic_burstlen = 16'd1; dc_burstlen = 16'd1;
    ic_rdreq = 1'b1; dc_rdreq = 1'b1; mem_valid = 1'b1;
    repeat (15) begin
      step();
      #1;
      if (mem_rdreq) q.push_back(mem_addr == 32'h4000 ? 1 : 2);
    end
    chk("t3_ngrants", q.size(), 5);
    if (q.size() >= 4) begin
      chk("t3_g0", q[0], 1);
      chk("t3_g1", q[1], 2);
      chk("t3_g2", q[2], 1);
      chk("t3_g3", q[3], 2);
    end
    ic_rdreq = 1'b0; dc_rdreq = 1'b0; mem_valid = 1'b0;
    step(); step(); step();

    // dcache read+write together, zero burst length
    dc_addr = 32'h7000; dc_burstlen = 16'd0;
    dc_rdreq = 1'b1; dc_wrreq = 1'b1;
    step();
    chk("t4_wrreq", mem_wrreq, 1'b1);
    chk("t4_rdreq", mem_rdreq, 1'b0);
    mem_valid = 1'b1;
    #1 chk("t4_valid", dc_valid, 1'b1);
    step();
    mem_valid = 1'b0; dc_rdreq = 1'b0; dc_wrreq = 1'b0;
    #1 chk("t4_gap_wrreq", mem_wrreq, 1'b0);
    step();

    // abort after 2 of 8 beats, then reset mid-burst
    ic_addr = 32'h3000; ic_burstlen = 16'd8; ic_rdreq = 1'b1;
    step();
    dc_addr = 32'h6000; dc_burstlen = 16'd4; dc_rdreq = 1'b1;
    mem_valid = 1'b1;
    step();
    step();
    mem_valid = 1'b0; ic_rdreq = 1'b0;
    #1 chk("t5_abort_rdreq", mem_rdreq, 1'b0);
    step();
    step();
    chk("t5_dc_rdreq", mem_rdreq, 1'b1);
    chk("t5_dc_addr", mem_addr, 32'h6000);
    mem_valid = 1'b1; mem_out = 32'h77;
    step();
    #2 reset_n = 1'b0;
    #1;
    chk("t5_rst_rdreq", mem_rdreq, 1'b0);
    chk("t5_rst_dcvalid", dc_valid, 1'b0);
    chk("t5_rst_addr", mem_addr, 32'h0);
    chk("t5_rst_dcdata", dc_dataout, 32'h0);
    step();
    reset_n = 1'b1; mem_valid = 1'b0; dc_rdreq = 1'b0;
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
